// File: rtl/serial_add_ctrl.sv
// Byte-serial W-bit adder: one shared 8-bit add stage, LSB slice first.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined (adds port sub).
module serial_add_ctrl #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic                  sub,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout
);

   localparam int unsigned W    = 8 * NBYTES;
   localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, work_q, work_d;
   logic [IDXW-1:0] idx_q;
   logic            carry_q;
`ifdef SERIAL_ADD_SUB_EN
   logic            sub_q;
`endif

   logic            capture, step, load_res;
   logic            busy_d, done_d;
   logic [7:0]      a8, b8, s8;
   logic            c8;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and registered-output next values
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      step     = 1'b0;
      load_res = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               capture = 1'b1;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            step   = 1'b1;
            busy_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d  = DONE;
               load_res = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slice select, shared 8-bit add, and write-back of the current byte
   always_comb begin
      a8     = 8'd0;
      b8     = 8'd0;
      work_d = work_q;
      for (int i = 0; i < int'(NBYTES); i++) begin
         if (idx_q == IDXW'(i)) begin
            a8 = a_q[i*8 +: 8];
            b8 = b_q[i*8 +: 8];
         end
      end
`ifdef SERIAL_ADD_SUB_EN
      if (sub_q) b8 = ~b8;
`endif
      {c8, s8} = 9'(a8) + 9'(b8) + 9'(carry_q);
      for (int i = 0; i < int'(NBYTES); i++) begin
         if (idx_q == IDXW'(i)) work_d[i*8 +: 8] = s8;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_q   <= 1'b0;
`endif
         sum     <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (capture) begin
            a_q    <= a;
            b_q    <= b;
            work_q <= '0;
            idx_q  <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
         end else if (step) begin
            work_q  <= work_d;
            carry_q <= c8;
            if (!load_res) idx_q <= idx_q + IDXW'(1);
         end
         if (load_res) begin
            sum  <= work_d;
            cout <= c8;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (NBYTES=4): arithmetic/latency model plus directed literal checks.
module tb_serial_add_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8 * N;

   logic         clk = 1'b0;
   logic         rst, start, cin, sub;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.NBYTES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Model: an accepted request yields a+b+cin (or a-b) N edges later, then one idle edge
   int           e = 0;
   int           acc = 0;
   bit           pend = 1'b0;
   bit           seen_rst = 1'b0;
   logic [W:0]   m_res;
   logic [W-1:0] m_sum;
   logic         m_cout;

   always @(posedge clk) begin
      e++;
      if (rst) begin
         pend     = 1'b0;
         m_sum    = '0;
         m_cout   = 1'b0;
         seen_rst = 1'b1;
      end else if (!pend) begin
         if (start) begin
            pend  = 1'b1;
            acc   = e;
            m_res = sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1))
                        : ({1'b0, a} + {1'b0, b} + (W+1)'(cin));
         end
      end else begin
         if (e == acc + int'(N)) begin
            m_sum  = m_res[W-1:0];
            m_cout = m_res[W];
         end
         if (e == acc + int'(N) + 1) pend = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (seen_rst) begin
         chk("cyc_busy", 64'(busy), 64'(pend && (e - acc) < int'(N)));
         chk("cyc_done", 64'(done), 64'(pend && (e == acc + int'(N))));
         chk("cyc_sum",  64'(sum),  64'(m_sum));
         chk("cyc_cout", 64'(cout), 64'(m_cout));
      end
   end

   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic ts);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the first negedge after acceptance
   task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec);
      int n  = 1;
      int bc = 0;
      bit got = 1'b0;
      while (n <= 20) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) bc++;
         @(negedge clk);
         n++;
      end
      chk({name, "_done_seen"}, 64'(got), 64'd1);
      if (got) begin
         chk({name, "_latency"},  64'(n),    64'(N + 1));
         chk({name, "_busy_cyc"}, 64'(bc),   64'(N));
         chk({name, "_sum"},      64'(sum),  64'(es));
         chk({name, "_cout"},     64'(cout), 64'(ec));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum",  64'(sum),  64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      rst = 1'b0;

      op(32'd16, 32'd22, 1'b1, 1'b0);
      wait_done("add16_22", 32'd39, 1'b0);

      op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      wait_done("carry_chain", 32'h0000_0000, 1'b1);

      op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
      wait_done("mixed", 32'hACF1_3569, 1'b0);

      op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      wait_done("top_carry", 32'h0000_0001, 1'b1);

      // start held high through RUN and DONE with new operands
      @(negedge clk);
      a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 32'd43; b = 32'd91;
      wait_done("held_first", 32'h0000_0100, 1'b0);
      @(negedge clk);
      chk("held_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("held_accept_busy", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done("held_second", 32'd134, 1'b0);

      // reset at the second RUN edge aborts without a done pulse
      @(negedge clk);
      a = 32'd55; b = 32'd1; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum",  64'(sum),  64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'd0);
      end
      op(32'd55, 32'd1, 1'b0, 1'b0);
      wait_done("after_abort", 32'd56, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      op(32'd55, 32'd99, 1'b1, 1'b1);
      wait_done("sub_borrow", 32'hFFFF_FFD4, 1'b0);
      op(32'd99, 32'd12, 1'b0, 1'b1);
      wait_done("sub_noborrow", 32'd87, 1'b1);
      sub = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL provide parameter: NBYTES, default 4, number of 8-bit slices per operand (legal 2..8); W = 8*NBYTES.
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: start  input  1  request to begin an operation.
REQ-005 SHALL provide port: a  input  W  operand A.
REQ-006 SHALL provide port: b  input  W  operand B.
REQ-007 SHALL provide port: cin  input  1  carry-in to byte 0.
REQ-008 SHALL provide port: busy  output  1  high while slices are being processed.
REQ-009 SHALL provide port: done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL provide port: sum  output  W  registered result.
REQ-011 SHALL provide port: cout  output  1  registered carry-out of top byte.

Function
REQ-012 SHALL use exactly one 8-bit add stage (a8 + b8 + c1 -> s8, c1), shared over NBYTES cycles, LSB byte first.
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; no other states reachable.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b, cin (and sub under REQ-025), clear byte index to 0, enter RUN.
REQ-015 start SHALL be ignored in RUN and DONE; operands SHALL not be re-sampled until the next IDLE acceptance.
REQ-016 RUN: each edge SHALL add captured byte[idx] of A and B plus carry register, store the 8-bit result into working byte idx, update carry register, increment idx.
REQ-017 Carry register SHALL hold cin (or 1 under subtraction) for byte 0 and the previous slice's carry thereafter.
REQ-018 After the slice with idx = NBYTES-1, the FSM SHALL enter DONE; idx SHALL not wrap or advance beyond NBYTES-1.
REQ-019 On entry to DONE, sum SHALL load the full working register and cout the final carry; sum/cout SHALL hold until the next DONE entry or reset.
REQ-020 Latency: start accepted at edge k -> done=1 exactly in the cycle after edge k+NBYTES, for one cycle; DONE -> IDLE at the next edge unconditionally.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both.
REQ-022 Arithmetic SHALL be modulo 2^W for sum, with cout equal to bit W of the unbounded A+B+cin.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, busy=0, done=0, with priority over start and any state.
REQ-024 rst during RUN SHALL abort the operation with no done pulse; operands captured before the abort SHALL be discarded.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN defined: add input port sub (1 bit), captured with operands; sub=1 SHALL invert every B byte and force initial carry to 1 (cin ignored), giving sum = A-B mod 2^W, cout=1 meaning no borrow; sub=0 behaves as addition.
REQ-026 Macro SERIAL_ADD_SUB_EN undefined: port sub SHALL be absent and the block SHALL perform addition only.

Verification (NBYTES=4)
REQ-027 SHALL cover: a=16, b=22, cin=1 -> done in cycle after edge k+4, sum=39, cout=0, busy high exactly 4 cycles.
REQ-028 SHALL cover: a=0xFFFFFFFF, b=1, cin=0 -> sum=0x00000000, cout=1 (carry through all slices).
REQ-029 SHALL cover: a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0; then start held high through RUN/DONE with a=43, b=91 -> ignored until IDLE, next accepted result sum=134.
REQ-030 SHALL cover: start a=55, b=1, rst=1 at second RUN edge -> next cycle all outputs 0, state IDLE, no done pulse; new start then completes normally with sum=56.
REQ-031 SHALL cover (SERIAL_ADD_SUB_EN): a=55, b=99, sub=1 -> sum=0xFFFFFFD4, cout=0; a=99, b=12, sub=1 -> sum=87, cout=1.
